// File: rtl/exp_pkg.sv
// Shared types for the modular-exponentiation sequencer: FSM states, operand
// selects, default widths and an index-width helper.
package exp_pkg;

  localparam int unsigned WIDTH_DEF = 512;
  localparam int unsigned EBITS_DEF = 512;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SCAN,
    SQ,
    SQW,
    MU,
    MUW,
    CV,
    CVW,
    FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_SQ,
    OP_MU,
    OP_CV
  } op_sel_e;

  // Bit-index register width; a 1-bit exponent still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exp_scheduler.sv
// MSB-first square-and-multiply sequencer driving one shared Montgomery multiplier.
// Optional macro EXP_SKIP_LEADING_ZEROS_EN adds a SCAN state that skips leading exponent zeros.
module exp_scheduler
  import exp_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned EBITS = EBITS_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_xt,
  input  logic [WIDTH-1:0] in_rm,
  input  logic [EBITS-1:0] in_e,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result
);

  localparam int unsigned   IW    = idx_w(EBITS);
  localparam logic [IW-1:0] I_TOP = IW'(EBITS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] r_xt;
  logic [EBITS-1:0] r_e;
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    w_i_nxt;

  logic             r_busy;
  logic             r_done;
  logic             r_mul_start;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;

  logic             w_accept;
  logic             w_launch;
  logic             w_bit;
  logic             w_i_zero;
  op_sel_e          w_op;
  logic [WIDTH-1:0] w_opb;

  // Next state, accumulator/index updates and the operand select for the next launch.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_i_nxt     = r_i;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    w_op        = OP_SQ;
    w_opb       = '0;
    w_bit       = r_e[r_i];
    w_i_zero    = (r_i == '0);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_a_nxt     = in_rm;
          w_i_nxt     = I_TOP;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
`ifdef EXP_SKIP_LEADING_ZEROS_EN
        w_state_nxt = SCAN;
`else
        w_state_nxt = SQ;
`endif
      end
`ifdef EXP_SKIP_LEADING_ZEROS_EN
      SCAN: begin
        // First set bit seeds A with the base, saving the squarings of one.
        if (w_bit) begin
          w_a_nxt = r_xt;
          if (w_i_zero) begin
            w_state_nxt = CV;
          end else begin
            w_i_nxt     = r_i - IW'(1);
            w_state_nxt = SQ;
          end
        end else if (w_i_zero) begin
          w_state_nxt = CV;
        end else begin
          w_i_nxt = r_i - IW'(1);
        end
      end
`endif
      SQ: w_state_nxt = SQW;
      SQW: begin
        if (mul_done) begin
          w_a_nxt = mul_result;
          if (w_bit) begin
            w_state_nxt = MU;
          end else if (w_i_zero) begin
            w_state_nxt = CV;
          end else begin
            w_i_nxt     = r_i - IW'(1);
            w_state_nxt = SQ;
          end
        end
      end
      MU: w_state_nxt = MUW;
      MUW: begin
        if (mul_done) begin
          w_a_nxt = mul_result;
          if (w_i_zero) begin
            w_state_nxt = CV;
          end else begin
            w_i_nxt     = r_i - IW'(1);
            w_state_nxt = SQ;
          end
        end
      end
      CV: w_state_nxt = CVW;
      CVW: begin
        if (mul_done) begin
          w_state_nxt = FIN;
        end
      end
      FIN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Operands are registered on entry to a launch state, using the updated A.
    case (w_state_nxt)
      SQ: begin
        w_launch = 1'b1;
        w_op     = OP_SQ;
      end
      MU: begin
        w_launch = 1'b1;
        w_op     = OP_MU;
      end
      CV: begin
        w_launch = 1'b1;
        w_op     = OP_CV;
      end
      default: w_launch = 1'b0;
    endcase

    case (w_op)
      OP_MU:   w_opb = r_xt;
      OP_CV:   w_opb = WIDTH'(1);
      default: w_opb = w_a_nxt;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_xt        <= '0;
      r_e         <= '0;
      r_i         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mul_start <= 1'b0;
      r_result    <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_i         <= w_i_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == FIN);
      r_mul_start <= w_launch;
      if (w_accept) begin
        r_xt <= in_xt;
        r_e  <= in_e;
      end
      if (w_launch) begin
        r_mul_a <= w_a_nxt;
        r_mul_b <= w_opb;
      end
      if ((r_state == CVW) && mul_done) begin
        r_result <= mul_result;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

endmodule
